neuron_mac: RTL and testbench

Downstream multiply-accumulate stage of the neuron datapath. Consumes one pixel/weight pair per accepted cycle for a fixed number of terms per sample, accumulates the signed products with saturation, and adds a bias. It applies rounding shift, ReLU and output saturation, then presents a single-cycle-valid neuron result. A sample is framed by an Input_Valid start pulse; terms arrive on Term_Valid, contiguous or with bubbles.

---
 rtl/neuron_mac.sv | 126 ++++++++++++
 tb/tb_neuron_mac.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// Neuron multiply-accumulate stage: registered pixel*weight products are summed
// with saturation, biased, rounded, shifted, ReLU'd and clamped to OUT_W bits.
module neuron_mac #(
  parameter int N_TERMS = 28,
  parameter int PIX_W   = 8,
  parameter int W_W     = 8,
  parameter int ACC_W   = 24,
  parameter int SHIFT   = 7,
  parameter int OUT_W   = 8
) (
  input  logic             clk,
  input  logic             GlobalReset,
  input  logic             Input_Valid,
  input  logic             Term_Valid,
  input  logic [PIX_W-1:0] Pixel,
  input  logic [W_W-1:0]   Weight,
  input  logic [ACC_W-1:0] Bias,
  output logic [OUT_W-1:0] Neuron_Out,
  output logic             Out_Valid,
  output logic             Busy,
  output logic             Overflow
);
  localparam int PW    = PIX_W + W_W + 1;
  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);
  localparam logic signed [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W:0] RND = (ACC_W+1)'(2 ** (SHIFT - 1));
  localparam logic signed [ACC_W:0] OMAX = (ACC_W+1)'(2 ** OUT_W - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, FINISH} state_t;
  state_t state;

  logic signed [ACC_W-1:0] acc, bias_q;
  logic signed [PW-1:0]    prod;
  logic                    prod_vld;
  logic [CNT_W-1:0]        cnt;

  logic signed [PW-1:0]    px_ext, w_ext, prod_new;
  logic signed [ACC_W:0]   prod_ext, acc_sum, bias_sum, rnd, r;
  logic signed [ACC_W-1:0] acc_sat, sum_sat;
  logic                    acc_ovf, sum_ovf;
  logic [OUT_W-1:0]        res;

  always_comb begin
    px_ext   = PW'($signed({1'b0, Pixel}));
    w_ext    = PW'($signed(Weight));
    prod_new = px_ext * w_ext;

    prod_ext = prod_vld ? (ACC_W+1)'(prod) : '0;
    acc_sum  = (ACC_W+1)'(acc) + prod_ext;
    acc_ovf  = acc_sum[ACC_W] != acc_sum[ACC_W-1];
    acc_sat  = acc_ovf ? (acc_sum[ACC_W] ? MINV : MAXV) : acc_sum[ACC_W-1:0];

    bias_sum = (ACC_W+1)'(acc) + (ACC_W+1)'(bias_q);
    sum_ovf  = bias_sum[ACC_W] != bias_sum[ACC_W-1];
    sum_sat  = sum_ovf ? (bias_sum[ACC_W] ? MINV : MAXV) : bias_sum[ACC_W-1:0];

    // one extra bit so the rounding offset cannot wrap a saturated sum
    rnd = (ACC_W+1)'(sum_sat) + RND;
    r   = rnd >>> SHIFT;
    if (r[ACC_W])
      res = '0;
    else if (r > OMAX)
      res = '1;
    else
      res = r[OUT_W-1:0];
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      state      <= IDLE;
      acc        <= '0;
      bias_q     <= '0;
      prod       <= '0;
      prod_vld   <= 1'b0;
      cnt        <= '0;
      Neuron_Out <= '0;
      Out_Valid  <= 1'b0;
      Busy       <= 1'b0;
      Overflow   <= 1'b0;
    end else begin
      Out_Valid <= 1'b0;
      if (Input_Valid) begin
        // restart wins over every state, including FINISH
        state    <= ACCUM;
        acc      <= '0;
        cnt      <= '0;
        prod_vld <= 1'b0;
        Overflow <= 1'b0;
        bias_q   <= Bias;
        Busy     <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          ACCUM: begin
            acc <= acc_sat;
            if (acc_ovf) Overflow <= 1'b1;
            if (Term_Valid) begin
              prod     <= prod_new;
              prod_vld <= 1'b1;
              cnt      <= cnt + CNT_W'(1);
              if (cnt == LAST) state <= DRAIN;
            end else begin
              prod_vld <= 1'b0;
            end
          end
          DRAIN: begin
            acc      <= acc_sat;
            prod_vld <= 1'b0;
            if (acc_ovf) Overflow <= 1'b1;
            state    <= FINISH;
          end
          FINISH: begin
            Neuron_Out <= res;
            Out_Valid  <= 1'b1;
            if (sum_ovf) Overflow <= 1'b1;
            Busy       <= 1'b0;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: hand-computed sums, Out_Valid timing, aborts,
// bubbles and asynchronous reset.
module tb_neuron_mac;
  logic        clk = 1'b0;
  logic        GlobalReset;
  logic        Input_Valid, Term_Valid;
  logic [7:0]  Pixel, Weight;
  logic [23:0] Bias;
  logic [7:0]  Neuron_Out;
  logic        Out_Valid, Busy, Overflow;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ov_cnt = 0;
  int ov_cyc = 0;
  int ov_val = 0;
  int s_cyc = 0;
  int ov0;

  neuron_mac dut (
    .clk(clk), .GlobalReset(GlobalReset), .Input_Valid(Input_Valid),
    .Term_Valid(Term_Valid), .Pixel(Pixel), .Weight(Weight), .Bias(Bias),
    .Neuron_Out(Neuron_Out), .Out_Valid(Out_Valid), .Busy(Busy), .Overflow(Overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (Out_Valid) begin
      ov_cnt = ov_cnt + 1;
      ov_cyc = cyc;
      ov_val = int'(Neuron_Out);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // called at a negedge; Input_Valid occupies the current cycle
  task automatic start(input logic [23:0] b);
    Input_Valid = 1'b1;
    Term_Valid  = 1'b0;
    Bias        = b;
    s_cyc       = cyc;
    @(negedge clk);
    Input_Valid = 1'b0;
    check("busy_rise", int'(Busy), 1);
  endtask

  task automatic feed(input int n, input logic [7:0] p, input logic [7:0] w, input int nbub);
    int used = 0;
    for (int i = 0; i < n; i++) begin
      if (used < nbub && i % 5 == 3) begin
        Term_Valid = 1'b0;
        @(negedge clk);
        used++;
      end
      Term_Valid = 1'b1;
      Pixel      = p;
      Weight     = w;
      @(negedge clk);
    end
    Term_Valid = 1'b0;
  endtask

  task automatic run(input string tag, input logic [23:0] b, input logic [7:0] p,
                     input logic [7:0] w, input int exp_out, input int exp_ovf);
    ov0 = ov_cnt;
    start(b);
    feed(28, p, w, 0);
    repeat (6) @(negedge clk);
    check({tag, "_pulses"}, ov_cnt - ov0, 1);
    check({tag, "_lat"}, ov_cyc - s_cyc, 31);
    check({tag, "_out"}, ov_val, exp_out);
    check({tag, "_ovf"}, int'(Overflow), exp_ovf);
    check({tag, "_busy"}, int'(Busy), 0);
  endtask

  initial begin
    GlobalReset = 1'b1;
    Input_Valid = 1'b0;
    Term_Valid  = 1'b0;
    Pixel       = '0;
    Weight      = '0;
    Bias        = '0;
    #12;
    check("rst_out", int'(Neuron_Out), 0);
    check("rst_ov", int'(Out_Valid), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_ovf", int'(Overflow), 0);
    @(negedge clk);
    GlobalReset = 1'b0;
    @(negedge clk);

    // Term_Valid in IDLE is ignored
    feed(30, 8'd128, 8'd1, 0);
    repeat (4) @(negedge clk);
    check("idle_ignore", ov_cnt, 0);

    run("pos",  24'd0, 8'd128, 8'd1, 28, 0);      // 3584 -> 28
    run("relu", 24'd0, 8'd100, 8'hFF, 0, 0);      // -2800 -> 0
    run("clip", 24'd0, 8'd255, 8'd127, 255, 0);   // 906780 -> 7084 -> 255
    run("bsat", 24'h7FFFFF, 8'd255, 8'd127, 255, 1);
    repeat (3) @(negedge clk);
    check("ovf_sticky", int'(Overflow), 1);

    // abort after 10 terms, contiguous restart
    ov0 = ov_cnt;
    start(24'd0);
    feed(10, 8'd255, 8'd127, 0);
    start(24'd0);
    feed(28, 8'd128, 8'd1, 0);
    repeat (6) @(negedge clk);
    check("abort_pulses", ov_cnt - ov0, 1);
    check("abort_out", ov_val, 28);
    check("abort_lat", ov_cyc - s_cyc, 31);

    // abort, then 5 bubbles in the restarted sample
    ov0 = ov_cnt;
    start(24'd0);
    feed(10, 8'd255, 8'd127, 0);
    start(24'd0);
    feed(28, 8'd128, 8'd1, 5);
    repeat (6) @(negedge clk);
    check("bub_pulses", ov_cnt - ov0, 1);
    check("bub_out", ov_val, 28);
    check("bub_lat", ov_cyc - s_cyc, 36);

    // Input_Valid in FINISH aborts the pending result
    ov0 = ov_cnt;
    start(24'd0);
    feed(28, 8'd255, 8'd127, 0);
    @(negedge clk);
    start(24'd0);
    feed(28, 8'd128, 8'd1, 0);
    repeat (6) @(negedge clk);
    check("fin_abort_pulses", ov_cnt - ov0, 1);
    check("fin_abort_out", ov_val, 28);

    // Input_Valid in the Out_Valid cycle: both results appear
    ov0 = ov_cnt;
    start(24'd0);
    feed(28, 8'd255, 8'd127, 0);
    repeat (2) @(negedge clk);
    check("ovcyc_first", int'(Out_Valid), 1);
    check("ovcyc_first_val", int'(Neuron_Out), 255);
    start(24'd0);
    feed(28, 8'd100, 8'd1, 0);                    // 2800 -> 22
    repeat (6) @(negedge clk);
    check("ovcyc_pulses", ov_cnt - ov0, 2);
    check("ovcyc_out", ov_val, 22);

    // asynchronous reset mid-ACCUM
    check("pre_rst_out", int'(Neuron_Out), 22);
    ov0 = ov_cnt;
    start(24'd0);
    feed(15, 8'd255, 8'd127, 0);
    Term_Valid = 1'b1;
    #2 GlobalReset = 1'b1;
    #1;
    check("arst_busy", int'(Busy), 0);
    check("arst_out", int'(Neuron_Out), 0);
    check("arst_ov", int'(Out_Valid), 0);
    check("arst_ovf", int'(Overflow), 0);
    @(negedge clk);
    GlobalReset = 1'b0;
    feed(30, 8'd255, 8'd127, 0);
    repeat (6) @(negedge clk);
    check("arst_no_pulse", ov_cnt - ov0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
